// File: rtl/instr_assembler.sv
// Encodes symbolic instruction requests into MIPS words and writes them
// sequentially into instruction memory, with count/done/err status.
module instr_assembler #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 64,
    localparam int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [CNT_W-1:0]  count,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic        last_flag;
    logic [31:0] enc_word;
    logic        op_legal;
    logic        transfer;

    // Opcode/funct values must match exactly what the main control decoder expects.
    always_comb begin
        enc_word = '0;
        op_legal = 1'b1;
        case (op_sel)
            3'd0:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
            3'd1:    enc_word = {6'b100011, rs, rt, imm};
            3'd2:    enc_word = {6'b101011, rs, rt, imm};
            3'd3:    enc_word = {6'b001000, rs, rt, imm};
            3'd4:    enc_word = {6'b000101, rs, rt, imm};
            default: op_legal = 1'b0;
        endcase
    end

    assign in_ready = (state == S_LOAD);
    assign imem_we  = (state == S_WRITE);
    assign done     = (state == S_DONE);
    assign transfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_flag  <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            count      <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        imem_addr <= BASE_ADDR;
                        count     <= '0;
                        err       <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (transfer) begin
                        if (op_legal) begin
                            imem_wdata <= enc_word;
                            last_flag  <= in_last;
                            state      <= S_WRITE;
                        end else begin
                            // Illegal requests are dropped but can still terminate the program.
                            err <= 1'b1;
                            if (in_last)
                                state <= S_DONE;
                        end
                    end
                end
                S_WRITE: begin
                    imem_addr <= imem_addr + ADDR_W'(4);
                    count     <= count + CNT_W'(1);
                    if (last_flag || (count + CNT_W'(1) == CNT_W'(DEPTH)))
                        state <= S_DONE;
                    else
                        state <= S_LOAD;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_assembler.sv
// Directed testbench for instr_assembler: a DEPTH=64 instance for the main
// scenarios and a DEPTH=4 instance sharing the inputs for the full case.
module tb_instr_assembler;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last;
    logic [2:0]  op_sel;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    logic        in_ready, imem_we, done, err;
    logic [31:0] imem_addr, imem_wdata;
    logic [6:0]  count;

    logic        rdy_s, we_s, done_s, err_s;
    logic [31:0] addr_s, wdata_s;
    logic [2:0]  count_s;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] qa[$], qd[$], qa_s[$], qd_s[$];

    always #5 clk = ~clk;

    instr_assembler #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .done(done), .err(err)
    );

    instr_assembler #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(4)) dut_small (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_s),
        .in_last(in_last), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .imem_we(we_s), .imem_addr(addr_s), .imem_wdata(wdata_s),
        .count(count_s), .done(done_s), .err(err_s)
    );

    // Record every memory write away from the active edge.
    always @(negedge clk) begin
        if (imem_we) begin qa.push_back(imem_addr); qd.push_back(imem_wdata); end
        if (we_s)    begin qa_s.push_back(addr_s);  qd_s.push_back(wdata_s);  end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        qa.delete(); qd.delete(); qa_s.delete(); qd_s.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic present(input logic [2:0] o, input logic [4:0] s, input logic [4:0] t,
                           input logic [4:0] d, input logic [15:0] i, input logic l);
        op_sel = o; rs = s; rt = t; rd = d; imm = i; in_last = l; in_valid = 1'b1;
    endtask

    // Present a request and complete its transfer, bounded by a cycle budget.
    task automatic send(input logic [2:0] o, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] i, input logic l);
        int waited = 0;
        present(o, s, t, d, i, l);
        while (!in_ready && waited < 8) begin tick(); waited++; end
        nvec++;
        if (!in_ready) begin
            nerr++;
            $display("[TB] FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        present(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        tick(); tick();
        start = 1'b0; in_valid = 1'b0;
        nvec += 7;
        if (in_ready !== 1'b0)      begin nerr++; $display("[TB] FAIL rst_ready got %0b exp 0", in_ready); end
        if (imem_we !== 1'b0)       begin nerr++; $display("[TB] FAIL rst_we got %0b exp 0", imem_we); end
        if (imem_addr !== 32'h0)    begin nerr++; $display("[TB] FAIL rst_addr got %h exp 0", imem_addr); end
        if (imem_wdata !== 32'h0)   begin nerr++; $display("[TB] FAIL rst_wdata got %h exp 0", imem_wdata); end
        if (count !== 7'd0)         begin nerr++; $display("[TB] FAIL rst_count got %0d exp 0", count); end
        if (done !== 1'b0)          begin nerr++; $display("[TB] FAIL rst_done got %0b exp 0", done); end
        if (err !== 1'b0)           begin nerr++; $display("[TB] FAIL rst_err got %0b exp 0", err); end
        rst = 1'b0;
        tick();
        nvec++;
        if (in_ready !== 1'b0)      begin nerr++; $display("[TB] FAIL idle_ready got %0b exp 0", in_ready); end
    endtask

    task automatic test_single_add();
        clear_q();
        pulse_start();
        nvec++;
        if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL load_ready got %0b exp 1", in_ready); end
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
        in_valid = 1'b0;
        nvec += 4;
        if (imem_we !== 1'b1)          begin nerr++; $display("[TB] FAIL add_we got %0b exp 1", imem_we); end
        if (imem_addr !== 32'h0)       begin nerr++; $display("[TB] FAIL add_addr got %h exp 0", imem_addr); end
        if (imem_wdata !== 32'h00221820) begin nerr++; $display("[TB] FAIL add_wdata got %h exp 00221820", imem_wdata); end
        if (in_ready !== 1'b0)         begin nerr++; $display("[TB] FAIL add_ready got %0b exp 0", in_ready); end
        tick();
        nvec += 3;
        if (count !== 7'd1)    begin nerr++; $display("[TB] FAIL add_count got %0d exp 1", count); end
        if (done !== 1'b1)     begin nerr++; $display("[TB] FAIL add_done got %0b exp 1", done); end
        if (imem_we !== 1'b0)  begin nerr++; $display("[TB] FAIL add_we_after got %0b exp 0", imem_we); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops[4]  = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [4:0]  rss[4]  = '{5'd0, 5'd29, 5'd0, 5'd8};
        logic [4:0]  rts[4]  = '{5'd8, 5'd31, 5'd9, 5'd9};
        logic [15:0] imms[4] = '{16'h0004, 16'hFFFC, 16'h0005, 16'hFFFE};
        logic [31:0] expw[4] = '{32'h8C080004, 32'hAFBFFFFC, 32'h20090005, 32'h1509FFFE};
        clear_q();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send(ops[i], rss[i], rts[i], 5'd0, imms[i], i == 3);
            nvec += 2;
            if (in_ready !== 1'b0) begin nerr++; $display("[TB] FAIL b2b_ready[%0d] got %0b exp 0", i, in_ready); end
            if (imem_we !== 1'b1)  begin nerr++; $display("[TB] FAIL b2b_we[%0d] got %0b exp 1", i, imem_we); end
        end
        in_valid = 1'b0;
        tick();
        nvec += 3;
        if (done !== 1'b1)   begin nerr++; $display("[TB] FAIL b2b_done got %0b exp 1", done); end
        if (count !== 7'd4)  begin nerr++; $display("[TB] FAIL b2b_count got %0d exp 4", count); end
        if (qa.size() != 4)  begin nerr++; $display("[TB] FAIL b2b_nwrites got %0d exp 4", qa.size()); end
        for (int i = 0; i < 4 && i < qa.size(); i++) begin
            nvec += 2;
            if (qa[i] !== 32'(4 * i)) begin nerr++; $display("[TB] FAIL b2b_addr[%0d] got %h exp %h", i, qa[i], 4 * i); end
            if (qd[i] !== expw[i])    begin nerr++; $display("[TB] FAIL b2b_data[%0d] got %h exp %h", i, qd[i], expw[i]); end
        end
    endtask

    task automatic test_illegal();
        clear_q();
        pulse_start();
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        send(3'd6, 5'd7, 5'd7, 5'd7, 16'h1234, 1'b0);
        nvec += 3;
        if (err !== 1'b1)      begin nerr++; $display("[TB] FAIL ill_err got %0b exp 1", err); end
        if (imem_we !== 1'b0)  begin nerr++; $display("[TB] FAIL ill_we got %0b exp 0", imem_we); end
        if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL ill_ready got %0b exp 1", in_ready); end
        send(3'd0, 5'd4, 5'd5, 5'd6, 16'h0, 1'b1);
        in_valid = 1'b0;
        tick();
        nvec += 4;
        if (err !== 1'b1)    begin nerr++; $display("[TB] FAIL ill_err_sticky got %0b exp 1", err); end
        if (count !== 7'd2)  begin nerr++; $display("[TB] FAIL ill_count got %0d exp 2", count); end
        if (done !== 1'b1)   begin nerr++; $display("[TB] FAIL ill_done got %0b exp 1", done); end
        if (qa.size() != 2)  begin nerr++; $display("[TB] FAIL ill_nwrites got %0d exp 2", qa.size()); end
        if (qa.size() == 2) begin
            nvec += 2;
            if (qa[1] !== 32'h4 || qd[1] !== 32'h00853020)
                begin nerr++; $display("[TB] FAIL ill_w1 got %h@%h exp 00853020@4", qd[1], qa[1]); end
            if (qa[0] !== 32'h0 || qd[0] !== 32'h00221820)
                begin nerr++; $display("[TB] FAIL ill_w0 got %h@%h exp 00221820@0", qd[0], qa[0]); end
        end
    endtask

    task automatic test_full();
        int acc = 0;
        rst = 1'b1; tick(); rst = 1'b0;
        clear_q();
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            int waited = 0;
            present(3'd0, 5'(i), 5'd1, 5'd2, 16'h0, 1'b0);
            while (!rdy_s && waited < 4) begin tick(); waited++; end
            if (rdy_s) begin tick(); acc++; end
        end
        in_valid = 1'b0;
        tick(); tick();
        nvec += 5;
        if (acc != 4)          begin nerr++; $display("[TB] FAIL full_accepted got %0d exp 4", acc); end
        if (qa_s.size() != 4)  begin nerr++; $display("[TB] FAIL full_nwrites got %0d exp 4", qa_s.size()); end
        if (done_s !== 1'b1)   begin nerr++; $display("[TB] FAIL full_done got %0b exp 1", done_s); end
        if (rdy_s !== 1'b0)    begin nerr++; $display("[TB] FAIL full_ready got %0b exp 0", rdy_s); end
        if (count_s !== 3'd4)  begin nerr++; $display("[TB] FAIL full_count got %0d exp 4", count_s); end
        if (qa_s.size() == 4) begin
            nvec++;
            if (qa_s[3] !== 32'hC) begin nerr++; $display("[TB] FAIL full_lastaddr got %h exp c", qa_s[3]); end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; tick(); rst = 1'b0;
        pulse_start();
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        in_valid = 1'b0;
        tick();
        send(3'd0, 5'd4, 5'd5, 5'd6, 16'h0, 1'b0);
        in_valid = 1'b0;
        nvec += 2;
        if (imem_we !== 1'b1)    begin nerr++; $display("[TB] FAIL mid_we got %0b exp 1", imem_we); end
        if (imem_addr !== 32'h4) begin nerr++; $display("[TB] FAIL mid_addr got %h exp 4", imem_addr); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nvec += 6;
        if (imem_we !== 1'b0)     begin nerr++; $display("[TB] FAIL mid_rst_we got %0b exp 0", imem_we); end
        if (imem_addr !== 32'h0)  begin nerr++; $display("[TB] FAIL mid_rst_addr got %h exp 0", imem_addr); end
        if (imem_wdata !== 32'h0) begin nerr++; $display("[TB] FAIL mid_rst_wdata got %h exp 0", imem_wdata); end
        if (count !== 7'd0)       begin nerr++; $display("[TB] FAIL mid_rst_count got %0d exp 0", count); end
        if (in_ready !== 1'b0)    begin nerr++; $display("[TB] FAIL mid_rst_ready got %0b exp 0", in_ready); end
        if (done !== 1'b0)        begin nerr++; $display("[TB] FAIL mid_rst_done got %0b exp 0", done); end
        clear_q();
        pulse_start();
        send(3'd3, 5'd0, 5'd9, 5'd0, 16'h0005, 1'b1);
        in_valid = 1'b0;
        tick();
        nvec += 2;
        if (count !== 7'd1) begin nerr++; $display("[TB] FAIL mid_restart_count got %0d exp 1", count); end
        if (qa.size() != 1 || qa[0] !== 32'h0 || qd[0] !== 32'h20090005)
            begin nerr++; $display("[TB] FAIL mid_restart_write got %0d writes, first %h", qa.size(), (qa.size() > 0) ? qa[0] : 32'hx); end
    endtask

    task automatic test_restart_done();
        clear_q();
        pulse_start();
        send(3'd7, 5'd1, 5'd1, 5'd1, 16'h0, 1'b1);
        in_valid = 1'b0;
        nvec += 4;
        if (done !== 1'b1)  begin nerr++; $display("[TB] FAIL rd_done got %0b exp 1", done); end
        if (err !== 1'b1)   begin nerr++; $display("[TB] FAIL rd_err got %0b exp 1", err); end
        if (count !== 7'd0) begin nerr++; $display("[TB] FAIL rd_count got %0d exp 0", count); end
        if (qa.size() != 0) begin nerr++; $display("[TB] FAIL rd_nwrites got %0d exp 0", qa.size()); end
        pulse_start();
        nvec += 3;
        if (done !== 1'b0)     begin nerr++; $display("[TB] FAIL rd_done_clr got %0b exp 0", done); end
        if (err !== 1'b0)      begin nerr++; $display("[TB] FAIL rd_err_clr got %0b exp 0", err); end
        if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL rd_ready got %0b exp 1", in_ready); end
        send(3'd1, 5'd0, 5'd8, 5'd0, 16'h0004, 1'b1);
        in_valid = 1'b0;
        tick();
        nvec += 2;
        if (count !== 7'd1) begin nerr++; $display("[TB] FAIL rd_count2 got %0d exp 1", count); end
        if (qa.size() != 1 || qa[0] !== 32'h0 || qd[0] !== 32'h8C080004)
            begin nerr++; $display("[TB] FAIL rd_write got %0d writes, first %h", qa.size(), (qa.size() > 0) ? qd[0] : 32'hx); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        op_sel = '0; rs = '0; rt = '0; rd = '0; imm = '0;
        #1;
        test_reset();
        test_single_add();
        test_back_to_back();
        test_illegal();
        test_full();
        test_reset_mid();
        test_restart_done();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Writer-side counterpart of the main control decoder.
- Accepts symbolic instruction requests (add, lw, sw, addi, bne plus register and immediate fields) over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS word carrying the exact opcode/funct values the decoder recognises.
- Writes the words sequentially into instruction memory starting at a base address, with count, done and error status for the loader testbench.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- BASE_ADDR, 0, byte address of the first word written after start.
- DEPTH, 64, maximum number of words per program; CNT_W = clog2(DEPTH+1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; begins a new program load.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_last  input  1  qualifies the final request of the program.
- op_sel  input  3  0=add, 1=lw, 2=sw, 3=addi, 4=bne; 5-7 illegal.
- rs  input  5  source register field.
- rt  input  5  second register field.
- rd  input  5  destination field (add only).
- imm  input  16  immediate field (non-add only).
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  byte address of the write.
- imem_wdata  output  32  encoded instruction.
- count  output  CNT_W  words written since the last start.
- done  output  1  level; load finished.
- err  output  1  sticky; an illegal op_sel was presented.

Behaviour:
- Reset: on rst high at the clock edge, state=IDLE. in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, done=0, err=0. Reset mid-load aborts immediately; no further write is issued.
- Handshake: a transfer occurs on a cycle with in_valid && in_ready. Inputs are sampled only on a transfer.
- Encoding (combinational from the sampled fields, registered on the transfer):
  - add: {000000, rs, rt, rd, 00000, 100000}.
  - lw: {100011, rs, rt, imm}.
  - sw: {101011, rs, rt, imm}.
  - addi: {001000, rs, rt, imm}.
  - bne: {000101, rs, rt, imm}.
  - Unused fields are ignored.
- IDLE: in_ready=0. start -> LOAD, with imem_addr<=BASE_ADDR, count<=0, done<=0, err<=0.
- LOAD: in_ready=1.
  - Legal transfer: imem_wdata<=encoded word; last flag<=in_last; -> WRITE.
  - Illegal op transfer: err<=1, nothing is written. If in_last -> DONE, else stay in LOAD.
- WRITE: in_ready=0, imem_we=1 for exactly this cycle, using the current imem_addr and imem_wdata. Next edge: imem_addr+=4 (wraps modulo 2^ADDR_W), count+=1. Then:
  - last flag set, or count+1==DEPTH -> DONE.
  - otherwise -> LOAD.
- DONE: done=1, in_ready=0. start -> LOAD, re-initialised as from IDLE.
- Latency: a word is written 1 cycle after its transfer. Maximum throughput is 1 word per 2 cycles.
- Full: after DEPTH writes the block enters DONE even without in_last. Requests after that are not accepted (in_ready=0).
- start in LOAD or WRITE is ignored. start coincident with rst: reset wins.
- imem_addr and imem_wdata hold their values outside WRITE. imem_we is never asserted outside WRITE.

Test Plan:
- Reset then start; transfer add rs=1 rt=2 rd=3 -> one cycle later imem_we=1, addr=0x0, wdata=0x00221820. Next cycle count=1.
- Back-to-back valid stream with in_valid held high: lw rs=0 rt=8 imm=4; sw rs=29 rt=31 imm=0xFFFC; addi rs=0 rt=9 imm=5; bne rs=8 rt=9 imm=0xFFFE (in_last) -> writes 0x8C080004@0x0, 0xAFBFFFFC@0x4, 0x20090005@0x8, 0x1509FFFE@0xC. in_ready toggles 1/0; done=1 after the 4th write; count=4.
- Illegal op_sel=6 mid-stream between two legal adds -> err=1 sticky, exactly two writes at consecutive addresses, no write for the illegal request.
- DEPTH=4, send 6 requests with no in_last -> exactly 4 writes, done=1, in_ready=0 thereafter, count=4.
- rst asserted on the WRITE cycle of the 2nd word -> imem_we low the next cycle, all outputs at reset values. A new start restarts at BASE_ADDR with count=0.
- start pulse in DONE -> done clears, err clears, the next program is written from BASE_ADDR again.
